rgb_cycle: RTL and testbench
============================

RGB_CYCLE -- requirements
Module: rgb_cycle

Interface
REQ-001 SHALL have parameter N_CH, default 3: number of LED channels, legal 1..6.
REQ-002 SHALL have parameter BW, default 8: brightness width in bits, legal 4..12.
REQ-003 SHALL have parameter PRESC_W, default 20: prescaler counter width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port i_mode, input, 2 bits: mode select, 0=OFF, 1=CYCLE, 2=BREATHE, 3=STATIC.
REQ-007 SHALL have port i_speed, input, 5 bits: log2 of the strobe period, clamped to PRESC_W-1.
REQ-008 SHALL have port i_dim, input, BW bits: global dimmer.
REQ-009 SHALL have port i_static, input, N_CH*BW bits: per-channel level for STATIC mode, channel c at bits [c*BW +: BW].
REQ-010 SHALL have port i_sync, input, 1 bit: single-cycle pulse that restarts the pattern.
REQ-011 SHALL have port o_led, output, N_CH bits: delta-sigma LED drive.
REQ-012 SHALL have port o_level, output, N_CH*BW bits: registered dimmed level per channel.
REQ-013 SHALL have port o_strobe, output, 1 bit: prescaler tick.

Function
REQ-014 Prescaler: SHALL count 0..2^s-1, where s is clamped i_speed, and wrap.
- o_strobe = 1 for exactly the cycle in which the count equals 2^s-1.
- s=0 gives o_strobe constantly high.
REQ-015 Position counter pos, width BW+3:
- Range 0..6*2^BW-1.
- Increments by 1 on o_strobe only in CYCLE or BREATHE.
- Wraps 6*2^BW-1 -> 0.
- Holds its value in OFF and STATIC.
REQ-016 Channel c in CYCLE mode SHALL use p_c = (pos + c*2*2^BW) mod 6*2^BW, with seg = p_c>>BW and frac = p_c[BW-1:0].
- seg 0: raw = frac.
- seg 1 and 2: raw = 2^BW-1.
- seg 3: raw = 2^BW-1-frac.
- seg 4 and 5: raw = 0.
REQ-017 BREATHE mode: all channels SHALL share one raw value, computed from pos.
- raw = pos[BW-1:0] when pos[BW]=0.
- raw = 2^BW-1-pos[BW-1:0] when pos[BW]=1.
REQ-018 STATIC mode: raw_c = i_static channel c. OFF mode: raw_c = 0.
REQ-019 Dimmer: o_level_c = (raw_c * (i_dim+1)) >> BW.
- Full-width product, no overflow.
- i_dim = 2^BW-1 passes raw unchanged.
REQ-020 o_level SHALL update every cycle with one cycle latency from raw, in all modes.
REQ-021 Delta-sigma per channel: acc_c (BW bits) <= (acc_c + o_level_c) mod 2^BW; o_led_c <= carry out of that sum.
- Duty = o_level_c/2^BW exactly over any 2^BW-cycle window with constant level.
- Level 0 -> constant 0.
REQ-022 i_sync=1 SHALL clear pos and the prescaler on the next edge.
- No o_strobe in that cycle.
- Overrides a simultaneous strobe increment.
REQ-023 A mode change SHALL take effect on raw in the same cycle; o_level follows one cycle later; pos is not cleared.
REQ-024 A change of i_speed mid-count SHALL NOT stall: if the prescaler count is already >= 2^s-1, it SHALL strobe and wrap on the next cycle.

Reset
REQ-025 While rst=1, the following SHALL be zero:
- prescaler, pos, every acc_c;
- o_level, o_led, o_strobe.
REQ-026 On release of rst, the prescaler SHALL begin counting on the first rising edge, with no glitch on o_led.

Structure
REQ-027 Shared package rgb_cycle_pkg SHALL hold:
- mode encodings MODE_OFF, MODE_CYCLE, MODE_BREATHE, MODE_STATIC;
- segment constant SEG_PER_PERIOD=6.
REQ-028 The delta-sigma modulator SHALL be a sub-module ds_mod, parameterised by BW, instantiated N_CH times.
REQ-029 The shape calculation SHALL be combinational from registered pos; the channel offset c*2*2^BW SHALL be elaboration-time constant.

Verification
REQ-030 The bench SHALL cover these scenarios at BW=8, N_CH=3:
- rst pulse mid-run -> all outputs 0 within the reset, prescaler restarts from 0.
- i_speed=3, CYCLE mode -> o_strobe every 8 cycles; o_level ch0 ramps 0,1,2.. once per strobe; ch1 leads ch0 by 512 positions.
- CYCLE mode, i_dim=255, pos forced through 1535 -> wraps to 0; ch0 o_level 0 at pos 0, 255 at pos 256..767, 0 at pos 1024..1535.
- STATIC mode, i_static ch0=64, i_dim=255 -> o_led ch0 exactly 64 highs per 256 cycles; i_dim=127 -> o_level ch0 = 32.
- BREATHE mode, i_speed=0 -> all three o_level equal; 255 at pos 255, 255 at pos 256, 0 at pos 511.
- i_sync asserted coincident with o_strobe -> pos = 0 next cycle, no increment, prescaler = 0.

Source files
------------

// File: rtl/rgb_cycle_pkg.sv
// Shared encodings and constants for the RGB colour-cycle LED driver.
package rgb_cycle_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_CYCLE   = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_STATIC  = 2'd3
  } mode_e;

  localparam int unsigned SEG_PER_PERIOD = 6;

  // Phase offset of channel ch in whole segments; the result is always below SEG_PER_PERIOD.
  function automatic int unsigned seg_offset(input int unsigned ch);
    return (2 * ch) % SEG_PER_PERIOD;
  endfunction

endpackage

// File: rtl/rgb_cycle_ds.sv
// First-order delta-sigma modulator: the carry out of a level accumulator drives the LED.
module ds_mod #(
  parameter int unsigned BW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [BW-1:0] i_level,
  output logic          o_led
);

  logic [BW-1:0] acc_q;
  logic          led_q;
  logic [BW:0]   sum;

  assign sum   = {1'b0, acc_q} + {1'b0, i_level};
  assign o_led = led_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      led_q <= 1'b0;
    end else begin
      acc_q <= sum[BW-1:0];
      led_q <= sum[BW];
    end
  end

endmodule

// File: rtl/rgb_cycle.sv
// Multi-channel LED pattern generator: prescaled position counter, per-channel shape,
// global dimmer and delta-sigma drive.
module rgb_cycle
  import rgb_cycle_pkg::*;
#(
  parameter int unsigned N_CH    = 3,
  parameter int unsigned BW      = 8,
  parameter int unsigned PRESC_W = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         i_mode,
  input  logic [4:0]         i_speed,
  input  logic [BW-1:0]      i_dim,
  input  logic [N_CH*BW-1:0] i_static,
  input  logic               i_sync,
  output logic [N_CH-1:0]    o_led,
  output logic [N_CH*BW-1:0] o_level,
  output logic               o_strobe
);

  localparam int unsigned MaxSpeed = PRESC_W - 1;
  localparam int unsigned PosW     = BW + 3;
  localparam logic [PosW-1:0] Period = PosW'(SEG_PER_PERIOD << BW);

  mode_e              mode;
  logic [4:0]         speed_c;
  logic [PRESC_W-1:0] term;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PosW-1:0]    pos_q, pos_d;
  logic               strobe_hit;
  logic               advance;
  logic [BW-1:0]      raw_breathe;

  assign mode    = mode_e'(i_mode);
  assign speed_c = (32'(i_speed) > MaxSpeed) ? 5'(MaxSpeed) : i_speed;
  assign term    = (PRESC_W'(1) << speed_c) - PRESC_W'(1);

  // >= rather than == so a speed decrease mid-count wraps at once instead of stalling.
  assign strobe_hit = (presc_q >= term);
  assign o_strobe   = strobe_hit & ~i_sync & ~rst;
  assign advance    = o_strobe & ((mode == MODE_CYCLE) | (mode == MODE_BREATHE));

  always_comb begin
    presc_d = presc_q + PRESC_W'(1);
    if (i_sync || strobe_hit) presc_d = '0;
  end

  always_comb begin
    pos_d = pos_q;
    if (i_sync) begin
      pos_d = '0;
    end else if (advance) begin
      pos_d = (pos_q == Period - PosW'(1)) ? '0 : pos_q + PosW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      pos_q   <= '0;
    end else begin
      presc_q <= presc_d;
      pos_q   <= pos_d;
    end
  end

  assign raw_breathe = pos_q[BW] ? ~pos_q[BW-1:0] : pos_q[BW-1:0];

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    localparam logic [BW+3:0] Ofs = (BW + 4)'(seg_offset(c) << BW);

    logic [BW+3:0]   p_sum, p;
    logic [2:0]      seg;
    logic [BW-1:0]   frac;
    logic [BW-1:0]   raw;
    logic [2*BW-1:0] prod;
    logic [BW-1:0]   level_q;

    // Offset is below one period, so a single conditional subtract gives the modulo.
    assign p_sum = {1'b0, pos_q} + Ofs;
    assign p     = (p_sum >= {1'b0, Period}) ? p_sum - {1'b0, Period} : p_sum;
    assign seg   = 3'(p >> BW);
    assign frac  = p[BW-1:0];

    always_comb begin
      raw = '0;
      unique case (mode)
        MODE_OFF:     raw = '0;
        MODE_CYCLE: begin
          case (seg)
            3'd0:       raw = frac;
            3'd1, 3'd2: raw = '1;
            3'd3:       raw = ~frac;
            default:    raw = '0;
          endcase
        end
        MODE_BREATHE: raw = raw_breathe;
        MODE_STATIC:  raw = i_static[c*BW +: BW];
      endcase
    end

    // raw * (dim + 1) fits in 2*BW bits, so the dimmer never overflows.
    assign prod = {{BW{1'b0}}, raw} * {{BW{1'b0}}, i_dim} + {{BW{1'b0}}, raw};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) level_q <= '0;
      else     level_q <= BW'(prod >> BW);
    end

    assign o_level[c*BW +: BW] = level_q;

    ds_mod #(
      .BW (BW)
    ) u_ds (
      .clk     (clk),
      .rst     (rst),
      .i_level (level_q),
      .o_led   (o_led[c])
    );
  end

endmodule

// File: tb/tb_rgb_cycle.sv
// Self-checking bench for rgb_cycle: cycle model feeds a scoreboard of expected level/LED words.
module tb_rgb_cycle;

  localparam int PER = 1536;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  i_mode;
  logic [4:0]  i_speed;
  logic [7:0]  i_dim;
  logic [23:0] i_static;
  logic        i_sync;
  logic [2:0]  o_led;
  logic [23:0] o_level;
  logic        o_strobe;

  int n_tests = 0;
  int n_fail  = 0;

  logic [26:0] exp_q[$];
  int m_presc, m_pos;
  int m_level[3];
  int m_acc[3];

  always #5 clk = ~clk;

  rgb_cycle #(
    .N_CH    (3),
    .BW      (8),
    .PRESC_W (20)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_mode   (i_mode),
    .i_speed  (i_speed),
    .i_dim    (i_dim),
    .i_static (i_static),
    .i_sync   (i_sync),
    .o_led    (o_led),
    .o_level  (o_level),
    .o_strobe (o_strobe)
  );

  function automatic int m_term();
    int s;
    s = (i_speed > 5'd19) ? 19 : int'(i_speed);
    return (1 << s) - 1;
  endfunction

  function automatic bit m_strobe();
    return !i_sync && (m_presc >= m_term());
  endfunction

  function automatic int m_raw(input int c);
    int p, seg, frac;
    case (i_mode)
      2'd1: begin
        p    = (m_pos + c * 512) % PER;
        seg  = p / 256;
        frac = p % 256;
        if (seg == 0) return frac;
        else if (seg < 3) return 255;
        else if (seg == 3) return 255 - frac;
        else return 0;
      end
      2'd2: return ((m_pos / 256) % 2 == 1) ? 255 - (m_pos % 256) : m_pos % 256;
      2'd3: return int'(i_static[c*8 +: 8]);
      default: return 0;
    endcase
  endfunction

  // Advance DUT and model one clock; push the expected post-edge outputs.
  task automatic tick();
    logic [26:0] e;
    bit st;
    int nl[3];
    int sum;
    st = m_strobe();
    for (int c = 0; c < 3; c++) begin
      nl[c] = m_raw(c) * (int'(i_dim) + 1) / 256;
      sum = m_acc[c] + m_level[c];
      e[24+c] = (sum >= 256);
      e[c*8 +: 8] = 8'(nl[c]);
    end
    exp_q.push_back(e);
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      sum = m_acc[c] + m_level[c];
      m_acc[c] = sum % 256;
      m_level[c] = nl[c];
    end
    if (i_sync) begin
      m_presc = 0;
      m_pos = 0;
    end else begin
      m_presc = st ? 0 : m_presc + 1;
      if (st && (i_mode == 2'd1 || i_mode == 2'd2)) m_pos = (m_pos + 1) % PER;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    m_presc = 0;
    m_pos = 0;
    for (int c = 0; c < 3; c++) begin
      m_level[c] = 0;
      m_acc[c] = 0;
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [26:0] e;
    do_reset();
    i_mode = 2'd1; i_speed = 5'd3; i_dim = 8'd255;
    for (int i = 0; i < 30; i++) begin
      tick();
      e = exp_q.pop_front();
      n_tests++;
      if ({o_led, o_level} !== e) begin
        n_fail++;
        $display("FAIL reset_prerun: got %h expected %h", {o_led, o_level}, e);
      end
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({o_led, o_level, o_strobe} !== 28'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", {o_led, o_level, o_strobe});
    end
    @(negedge clk);
    n_tests++;
    if ({o_led, o_level, o_strobe} !== 28'd0) begin
      n_fail++;
      $display("FAIL reset_held: got %h expected 0", {o_led, o_level, o_strobe});
    end
    m_presc = 0;
    m_pos = 0;
    for (int c = 0; c < 3; c++) begin
      m_level[c] = 0;
      m_acc[c] = 0;
    end
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      n_tests++;
      if (o_strobe !== (k == 7)) begin
        n_fail++;
        $display("FAIL reset_restart k=%0d: strobe %b expected %b", k, o_strobe, (k == 7));
      end
      tick();
      e = exp_q.pop_front();
      n_tests++;
      if ({o_led, o_level} !== e) begin
        n_fail++;
        $display("FAIL reset_post: got %h expected %h", {o_led, o_level}, e);
      end
    end
  endtask

  task automatic test_cycle_ramp();
    logic [26:0] e;
    int nstr, pb;
    do_reset();
    i_mode = 2'd1; i_speed = 5'd3; i_dim = 8'd255;
    nstr = 0;
    for (int i = 0; i < 100; i++) begin
      n_tests++;
      if (o_strobe !== m_strobe()) begin
        n_fail++;
        $display("FAIL ramp_strobe cyc=%0d: got %b expected %b", i, o_strobe, m_strobe());
      end
      pb = nstr;
      if ((i % 8) == 7) nstr++;
      tick();
      e = exp_q.pop_front();
      n_tests++;
      if ({o_led, o_level} !== e) begin
        n_fail++;
        $display("FAIL ramp_sb: got %h expected %h", {o_led, o_level}, e);
      end
      n_tests++;
      if (o_level !== {8'd0, 8'd255, 8'(pb)}) begin
        n_fail++;
        $display("FAIL ramp_levels: got %h expected %h", o_level, {8'd0, 8'd255, 8'(pb)});
      end
    end
  endtask

  task automatic test_cycle_wrap();
    logic [26:0] e;
    int pb, ex;
    do_reset();
    i_mode = 2'd1; i_speed = 5'd0; i_dim = 8'd255;
    for (int i = 0; i < 1541; i++) begin
      pb = i % PER;
      tick();
      e = exp_q.pop_front();
      n_tests++;
      if ({o_led, o_level} !== e) begin
        n_fail++;
        $display("FAIL wrap_sb pos=%0d: got %h expected %h", pb, {o_led, o_level}, e);
      end
      if (pb < 256) ex = pb;
      else if (pb < 768) ex = 255;
      else if (pb < 1024) ex = 1023 - pb;
      else ex = 0;
      n_tests++;
      if (o_level[7:0] !== 8'(ex)) begin
        n_fail++;
        $display("FAIL wrap_ch0 pos=%0d: got %0d expected %0d", pb, o_level[7:0], ex);
      end
    end
  endtask

  task automatic test_static();
    logic [26:0] e;
    int cnt[3];
    do_reset();
    i_mode = 2'd3; i_speed = 5'd0; i_dim = 8'd255;
    i_static = {8'd0, 8'd200, 8'd64};
    for (int c = 0; c < 3; c++) cnt[c] = 0;
    for (int i = 0; i < 258; i++) begin
      tick();
      e = exp_q.pop_front();
      n_tests++;
      if ({o_led, o_level} !== e) begin
        n_fail++;
        $display("FAIL static_sb: got %h expected %h", {o_led, o_level}, e);
      end
      if (i >= 2) for (int c = 0; c < 3; c++) cnt[c] += int'(o_led[c]);
    end
    n_tests++;
    if (cnt[0] != 64) begin
      n_fail++;
      $display("FAIL static_duty0: got %0d highs expected 64", cnt[0]);
    end
    n_tests++;
    if (cnt[1] != 200) begin
      n_fail++;
      $display("FAIL static_duty1: got %0d highs expected 200", cnt[1]);
    end
    n_tests++;
    if (cnt[2] != 0) begin
      n_fail++;
      $display("FAIL static_duty2: got %0d highs expected 0", cnt[2]);
    end
    i_dim = 8'd127;
    tick();
    e = exp_q.pop_front();
    n_tests++;
    if (o_level !== {8'd0, 8'd100, 8'd32}) begin
      n_fail++;
      $display("FAIL static_dim: got %h expected %h", o_level, {8'd0, 8'd100, 8'd32});
    end
  endtask

  task automatic test_breathe();
    logic [26:0] e;
    int pb;
    do_reset();
    i_mode = 2'd2; i_speed = 5'd0; i_dim = 8'd255;
    for (int i = 0; i < 520; i++) begin
      pb = i;
      tick();
      e = exp_q.pop_front();
      n_tests++;
      if ({o_led, o_level} !== e) begin
        n_fail++;
        $display("FAIL breathe_sb pos=%0d: got %h expected %h", pb, {o_led, o_level}, e);
      end
      n_tests++;
      if (o_level[7:0] !== o_level[15:8] || o_level[7:0] !== o_level[23:16]) begin
        n_fail++;
        $display("FAIL breathe_equal pos=%0d: got %h", pb, o_level);
      end
      if (pb == 255 || pb == 256 || pb == 511) begin
        n_tests++;
        if (o_level[7:0] !== ((pb == 511) ? 8'd0 : 8'd255)) begin
          n_fail++;
          $display("FAIL breathe_spot pos=%0d: got %0d", pb, o_level[7:0]);
        end
      end
    end
  endtask

  task automatic test_sync();
    logic [26:0] e;
    bit found;
    do_reset();
    i_mode = 2'd1; i_speed = 5'd3; i_dim = 8'd255;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_pos == 4 && m_strobe()) found = 1'b1;
      else begin
        tick();
        e = exp_q.pop_front();
      end
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL sync_setup: strobe at pos 4 not reached got 0 expected 1");
    end
    i_sync = 1'b1;
    #1;
    n_tests++;
    if (o_strobe !== 1'b0) begin
      n_fail++;
      $display("FAIL sync_nostrobe: got %b expected 0", o_strobe);
    end
    tick();
    e = exp_q.pop_front();
    i_sync = 1'b0;
    for (int k = 0; k < 10; k++) begin
      n_tests++;
      if (o_strobe !== (k == 7)) begin
        n_fail++;
        $display("FAIL sync_presc k=%0d: strobe %b expected %b", k, o_strobe, (k == 7));
      end
      tick();
      e = exp_q.pop_front();
      n_tests++;
      if ({o_led, o_level} !== e) begin
        n_fail++;
        $display("FAIL sync_sb: got %h expected %h", {o_led, o_level}, e);
      end
      if (k == 0 || k == 8) begin
        n_tests++;
        if (o_level[7:0] !== ((k == 0) ? 8'd0 : 8'd1)) begin
          n_fail++;
          $display("FAIL sync_pos k=%0d: ch0 got %0d", k, o_level[7:0]);
        end
      end
    end
  endtask

  task automatic test_speed_change();
    logic [26:0] e;
    do_reset();
    i_mode = 2'd1; i_speed = 5'd5; i_dim = 8'd255;
    for (int i = 0; i < 20; i++) begin
      tick();
      e = exp_q.pop_front();
    end
    i_speed = 5'd2;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_tests++;
      if (o_strobe !== (k == 0 || k == 4)) begin
        n_fail++;
        $display("FAIL speed_change k=%0d: strobe %b expected %b", k, o_strobe, (k == 0 || k == 4));
      end
      tick();
      e = exp_q.pop_front();
      n_tests++;
      if ({o_led, o_level} !== e) begin
        n_fail++;
        $display("FAIL speed_sb: got %h expected %h", {o_led, o_level}, e);
      end
    end
  endtask

  task automatic test_off_hold();
    logic [26:0] e;
    do_reset();
    i_mode = 2'd1; i_speed = 5'd0; i_dim = 8'd255;
    for (int i = 0; i < 300; i++) begin
      tick();
      e = exp_q.pop_front();
    end
    i_mode = 2'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      e = exp_q.pop_front();
      n_tests++;
      if ({o_led, o_level} !== e || o_level !== 24'd0) begin
        n_fail++;
        $display("FAIL off_level: got %h expected %h", {o_led, o_level}, e);
      end
    end
    i_mode = 2'd1;
    tick();
    e = exp_q.pop_front();
    n_tests++;
    if (o_level !== {8'd0, 8'd211, 8'd255}) begin
      n_fail++;
      $display("FAIL off_hold: got %h expected %h", o_level, {8'd0, 8'd211, 8'd255});
    end
  endtask

  initial begin
    rst = 1'b1;
    i_mode = 2'd0; i_speed = 5'd0; i_dim = 8'd255; i_static = 24'd0; i_sync = 1'b0;
    test_reset();
    test_cycle_ramp();
    test_cycle_wrap();
    test_static();
    test_breathe();
    test_sync();
    test_speed_change();
    test_off_hold();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
